// File: rtl/ddr3_axi_arb2_if.sv
// AXI4 channel bundle used for the two upstream masters and the DDR3 core port.
// The clk/rst members exist for bus compatibility only; the arbiter uses its own clock and reset.
interface ddr3_core_uif #(
    parameter int ID_W   = 12,
    parameter int ADDR_W = 33,
    parameter int DATA_W = 256
);
    logic                clk;
    logic                rst;

    logic                awvalid;
    logic                awready;
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;

    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;

    logic                bvalid;
    logic                bready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;

    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;

    logic                rvalid;
    logic                rready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast,
        output bready,
        output arvalid, arid, araddr, arlen, arsize, arburst,
        output rready,
        input  awready, wready, bvalid, bid, bresp,
        input  arready, rvalid, rid, rdata, rresp, rlast
    );

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast,
        input  bready,
        input  arvalid, arid, araddr, arlen, arsize, arburst,
        input  rready,
        output awready, wready, bvalid, bid, bresp,
        output arready, rvalid, rid, rdata, rresp, rlast
    );
endinterface

// File: rtl/ddr3_axi_arb2.sv
// Two-master AXI4 arbiter in front of one DDR3 core slave port.
// Round-robin AR/AW, W locked to the AW winner, B/R routed back by the prepended ID MSB.
module ddr3_axi_arb2 #(
    parameter int ID_W    = 12,
    parameter int ADDR_W  = 33,
    parameter int DATA_W  = 256,
    parameter int MAX_OUT = 8
) (
    input  logic         clk,
    input  logic         rst,
    ddr3_core_uif.slave  s0,
    ddr3_core_uif.slave  s1,
    ddr3_core_uif.master m,
    output logic [1:0]   wlast_err
);
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA} wstate_t;
    typedef enum logic       {R_IDLE, R_ADDR}         rstate_t;

    wstate_t    r_wstate, w_wstate_next;
    rstate_t    r_rstate, w_rstate_next;
    logic       r_gw, r_gr;
    logic       r_aw_last, r_ar_last;
    logic [7:0] r_awlen, r_beat;
    logic [1:0] r_wlast_err;

    logic [1:0] w_awvalid_vec, w_arvalid_vec;
    logic [1:0] w_aw_elig, w_ar_elig;
    logic       w_aw_pick, w_ar_pick;
    logic       w_sel_awvalid, w_sel_wvalid, w_sel_wlast, w_sel_arvalid;
    logic       w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs;
    logic       w_b_port, w_r_port;

    assign w_awvalid_vec = {s1.awvalid, s0.awvalid};
    assign w_arvalid_vec = {s1.arvalid, s0.arvalid};

    // With both ports eligible the one not granted last wins.
    assign w_aw_pick = (&w_aw_elig) ? ~r_aw_last : w_aw_elig[1];
    assign w_ar_pick = (&w_ar_elig) ? ~r_ar_last : w_ar_elig[1];

    assign w_sel_awvalid = r_gw ? s1.awvalid : s0.awvalid;
    assign w_sel_wvalid  = r_gw ? s1.wvalid  : s0.wvalid;
    assign w_sel_wlast   = r_gw ? s1.wlast   : s0.wlast;
    assign w_sel_arvalid = r_gr ? s1.arvalid : s0.arvalid;

    assign w_aw_hs  = (r_wstate == W_ADDR) && w_sel_awvalid && m.awready;
    assign w_w_hs   = (r_wstate == W_DATA) && w_sel_wvalid && m.wready;
    assign w_ar_hs  = (r_rstate == R_ADDR) && w_sel_arvalid && m.arready;
    assign w_b_port = m.bid[ID_W-1];
    assign w_r_port = m.rid[ID_W-1];
    assign w_b_hs   = m.bvalid && m.bready;
    assign w_r_hs   = m.rvalid && m.rready;

    // Downstream address/data muxes; payload is don't-care while the matching valid is low.
    assign m.awid    = {r_gw, (r_gw ? s1.awid : s0.awid)};
    assign m.awaddr  = r_gw ? s1.awaddr  : s0.awaddr;
    assign m.awlen   = r_gw ? s1.awlen   : s0.awlen;
    assign m.awsize  = r_gw ? s1.awsize  : s0.awsize;
    assign m.awburst = r_gw ? s1.awburst : s0.awburst;
    assign m.wdata   = r_gw ? s1.wdata   : s0.wdata;
    assign m.wstrb   = r_gw ? s1.wstrb   : s0.wstrb;
    assign m.wlast   = w_sel_wlast;
    assign m.arid    = {r_gr, (r_gr ? s1.arid : s0.arid)};
    assign m.araddr  = r_gr ? s1.araddr  : s0.araddr;
    assign m.arlen   = r_gr ? s1.arlen   : s0.arlen;
    assign m.arsize  = r_gr ? s1.arsize  : s0.arsize;
    assign m.arburst = r_gr ? s1.arburst : s0.arburst;

    // Response routing keyed on the ID MSB, no added latency.
    assign s0.bvalid = m.bvalid && !w_b_port;
    assign s1.bvalid = m.bvalid &&  w_b_port;
    assign s0.bid    = m.bid[ID_W-2:0];
    assign s1.bid    = m.bid[ID_W-2:0];
    assign s0.bresp  = m.bresp;
    assign s1.bresp  = m.bresp;
    assign m.bready  = w_b_port ? s1.bready : s0.bready;

    assign s0.rvalid = m.rvalid && !w_r_port;
    assign s1.rvalid = m.rvalid &&  w_r_port;
    assign s0.rid    = m.rid[ID_W-2:0];
    assign s1.rid    = m.rid[ID_W-2:0];
    assign s0.rdata  = m.rdata;
    assign s1.rdata  = m.rdata;
    assign s0.rresp  = m.rresp;
    assign s1.rresp  = m.rresp;
    assign s0.rlast  = m.rlast;
    assign s1.rlast  = m.rlast;
    assign m.rready  = w_r_port ? s1.rready : s0.rready;

    assign wlast_err = r_wlast_err;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [CNT_W-1:0] r_wr_cnt;
            logic [CNT_W-1:0] r_rd_cnt;
            logic             w_wr_inc, w_wr_dec, w_rd_inc, w_rd_dec;

            assign w_wr_inc = w_aw_hs && (r_gw == 1'(gi));
            assign w_wr_dec = w_b_hs && (w_b_port == 1'(gi));
            assign w_rd_inc = w_ar_hs && (r_gr == 1'(gi));
            assign w_rd_dec = w_r_hs && m.rlast && (w_r_port == 1'(gi));

            assign w_aw_elig[gi] = w_awvalid_vec[gi] && (r_wr_cnt < CNT_W'(MAX_OUT));
            assign w_ar_elig[gi] = w_arvalid_vec[gi] && (r_rd_cnt < CNT_W'(MAX_OUT));

            // Simultaneous inc/dec cancel; a stray decrement at zero is ignored.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wr_cnt <= '0;
                    r_rd_cnt <= '0;
                end else begin
                    if (w_wr_inc && !w_wr_dec)
                        r_wr_cnt <= r_wr_cnt + CNT_W'(1);
                    else if (w_wr_dec && !w_wr_inc && (r_wr_cnt != '0))
                        r_wr_cnt <= r_wr_cnt - CNT_W'(1);
                    if (w_rd_inc && !w_rd_dec)
                        r_rd_cnt <= r_rd_cnt + CNT_W'(1);
                    else if (w_rd_dec && !w_rd_inc && (r_rd_cnt != '0))
                        r_rd_cnt <= r_rd_cnt - CNT_W'(1);
                end
            end
        end
    endgenerate

    always_comb begin
        w_wstate_next = r_wstate;
        m.awvalid     = 1'b0;
        m.wvalid      = 1'b0;
        s0.awready    = 1'b0;
        s1.awready    = 1'b0;
        s0.wready     = 1'b0;
        s1.wready     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (|w_aw_elig) w_wstate_next = W_ADDR;
            end
            W_ADDR: begin
                m.awvalid  = w_sel_awvalid;
                s0.awready = !r_gw && m.awready;
                s1.awready =  r_gw && m.awready;
                if (w_aw_hs) w_wstate_next = W_DATA;
            end
            W_DATA: begin
                m.wvalid  = w_sel_wvalid;
                s0.wready = !r_gw && m.wready;
                s1.wready =  r_gw && m.wready;
                if (w_w_hs && w_sel_wlast) w_wstate_next = W_IDLE;
            end
            default: w_wstate_next = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_next = r_rstate;
        m.arvalid     = 1'b0;
        s0.arready    = 1'b0;
        s1.arready    = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                if (|w_ar_elig) w_rstate_next = R_ADDR;
            end
            R_ADDR: begin
                m.arvalid  = w_sel_arvalid;
                s0.arready = !r_gr && m.arready;
                s1.arready =  r_gr && m.arready;
                if (w_ar_hs) w_rstate_next = R_IDLE;
            end
            default: w_rstate_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_next;
            r_rstate <= w_rstate_next;
        end
    end

    // r_*_last starts at 1 so that s0 wins the first contested grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gw        <= 1'b0;
            r_gr        <= 1'b0;
            r_aw_last   <= 1'b1;
            r_ar_last   <= 1'b1;
            r_awlen     <= '0;
            r_beat      <= '0;
            r_wlast_err <= '0;
        end else begin
            if (r_wstate == W_IDLE) r_gw <= w_aw_pick;
            if (r_rstate == R_IDLE) r_gr <= w_ar_pick;
            if (w_ar_hs) r_ar_last <= r_gr;
            if (w_aw_hs) begin
                r_aw_last <= r_gw;
                r_awlen   <= m.awlen;
                r_beat    <= '0;
            end
            if (w_w_hs) begin
                r_beat <= r_beat + 8'd1;
                if (w_sel_wlast != (r_beat == r_awlen)) r_wlast_err[r_gw] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ddr3_axi_arb2.sv
// Directed bench for ddr3_axi_arb2: writes, round-robin reads, outstanding limit,
// response routing, W-burst length errors and mid-burst reset.
module tb_ddr3_axi_arb2;
    localparam int ID_W    = 4;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int MAX_OUT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] wlast_err;

    int n_chk = 0;
    int n_err = 0;

    ddr3_core_uif #(.ID_W(ID_W-1), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) if_s0 ();
    ddr3_core_uif #(.ID_W(ID_W-1), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) if_s1 ();
    ddr3_core_uif #(.ID_W(ID_W),   .ADDR_W(ADDR_W), .DATA_W(DATA_W)) if_m  ();

    assign if_s0.clk = clk;
    assign if_s0.rst = rst;
    assign if_s1.clk = clk;
    assign if_s1.rst = rst;
    assign if_m.clk  = clk;
    assign if_m.rst  = rst;

    ddr3_axi_arb2 #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s0(if_s0.slave),
        .s1(if_s1.slave),
        .m(if_m.master),
        .wlast_err(wlast_err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        {if_s0.awvalid, if_s0.wvalid, if_s0.arvalid, if_s0.wlast} = '0;
        {if_s1.awvalid, if_s1.wvalid, if_s1.arvalid, if_s1.wlast} = '0;
        if_s0.awid = '0; if_s0.awaddr = '0; if_s0.awlen = '0; if_s0.awsize = 3'd5; if_s0.awburst = 2'd1;
        if_s1.awid = '0; if_s1.awaddr = '0; if_s1.awlen = '0; if_s1.awsize = 3'd5; if_s1.awburst = 2'd1;
        if_s0.arid = '0; if_s0.araddr = '0; if_s0.arlen = '0; if_s0.arsize = 3'd5; if_s0.arburst = 2'd1;
        if_s1.arid = '0; if_s1.araddr = '0; if_s1.arlen = '0; if_s1.arsize = 3'd5; if_s1.arburst = 2'd1;
        if_s0.wdata = '0; if_s0.wstrb = '1; if_s1.wdata = '0; if_s1.wstrb = '1;
        if_s0.bready = 1'b1; if_s0.rready = 1'b1; if_s1.bready = 1'b1; if_s1.rready = 1'b1;
        if_m.awready = 1'b1; if_m.wready = 1'b1; if_m.arready = 1'b1;
        if_m.bvalid = 1'b0; if_m.bid = '0; if_m.bresp = '0;
        if_m.rvalid = 1'b0; if_m.rid = '0; if_m.rdata = '0; if_m.rresp = '0; if_m.rlast = 1'b0;

        // Reset state
        cyc(); cyc();
        chk("rst_awvalid", if_m.awvalid, 1'b0);
        chk("rst_wvalid", if_m.wvalid, 1'b0);
        chk("rst_arvalid", if_m.arvalid, 1'b0);
        chk("rst_s0_awready", if_s0.awready, 1'b0);
        chk("rst_s1_arready", if_s1.arready, 1'b0);
        chk("rst_wlast_err", wlast_err, 2'b00);
        cyc(); rst = 1'b0;

        // Single s0 write, awlen=3
        cyc(); if_s0.awvalid = 1'b1; if_s0.awid = 3'h5; if_s0.awaddr = 16'h0100; if_s0.awlen = 8'd3; #1;
        chk("t1_aw_latency", if_m.awvalid, 1'b0);
        cyc();
        chk("t1_awvalid", if_m.awvalid, 1'b1);
        chk("t1_awid", if_m.awid, 4'h5);
        chk("t1_awaddr", if_m.awaddr, 16'h0100);
        chk("t1_s0_awready", if_s0.awready, 1'b1);
        for (int b = 0; b < 4; b++) begin
            cyc();
            if (b == 0) begin
                if_s0.awvalid = 1'b0;
                if_s0.wvalid  = 1'b1;
            end
            if_s0.wdata = 32'hA000_0000 + 32'(b);
            if_s0.wlast = (b == 3);
            #1;
            chk("t1_wvalid", if_m.wvalid, 1'b1);
            chk("t1_wdata", if_m.wdata, 32'hA000_0000 + 32'(b));
            chk("t1_wlast", if_m.wlast, (b == 3));
            chk("t1_s1_wready", if_s1.wready, 1'b0);
            $display("t1 beat %0d data=%h", b, if_m.wdata);
        end
        cyc(); if_s0.wvalid = 1'b0; if_s0.wlast = 1'b0;
        if_m.bvalid = 1'b1; if_m.bid = 4'h5; if_m.bresp = 2'b00; #1;
        chk("t1_wvalid_end", if_m.wvalid, 1'b0);
        chk("t1_s0_wready_end", if_s0.wready, 1'b0);
        chk("t1_wlast_err", wlast_err, 2'b00);
        chk("t1_s0_bvalid", if_s0.bvalid, 1'b1);
        chk("t1_s1_bvalid", if_s1.bvalid, 1'b0);
        chk("t1_s0_bid", if_s0.bid, 3'h5);
        chk("t1_bready", if_m.bready, 1'b1);
        $display("t1 write s0 id=5 len=3 complete");
        cyc(); if_m.bvalid = 1'b0; #1;
        chk("t1_s0_bvalid_off", if_s0.bvalid, 1'b0);

        // Contested reads: alternating grants until both ports reach MAX_OUT
        cyc();
        if_s0.arvalid = 1'b1; if_s0.arid = 3'h1; if_s0.araddr = 16'h0200;
        if_s1.arvalid = 1'b1; if_s1.arid = 3'h2; if_s1.araddr = 16'h0300; #1;
        chk("t2_ar_latency", if_m.arvalid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t2_arvalid", if_m.arvalid, 1'b1);
            chk("t2_arid", if_m.arid, (i % 2 == 1) ? 4'hA : 4'h1);
            chk("t2_s0_arready", if_s0.arready, (i % 2 == 0));
            chk("t2_s1_arready", if_s1.arready, (i % 2 == 1));
            $display("t2 AR grant %0d arid=%h", i, if_m.arid);
            cyc();
            chk("t2_ar_gap", if_m.arvalid, 1'b0);
        end
        cyc(); if_s0.arvalid = 1'b0; #1;
        chk("t2_full_arvalid", if_m.arvalid, 1'b0);
        chk("t2_full_s1_arready", if_s1.arready, 1'b0);

        // R beats routed by rid MSB 1,0,1; s1 back-pressure first
        cyc(); if_m.rvalid = 1'b1; if_m.rid = 4'hA; if_m.rdata = 32'h0000_00B1; if_m.rlast = 1'b1;
        if_s1.rready = 1'b0; #1;
        chk("t3_r1_s1_rvalid", if_s1.rvalid, 1'b1);
        chk("t3_r1_s0_rvalid", if_s0.rvalid, 1'b0);
        chk("t3_r1_rdata", if_s1.rdata, 32'h0000_00B1);
        chk("t3_r1_rid", if_s1.rid, 3'h2);
        chk("t3_stall_rready", if_m.rready, 1'b0);
        chk("t3_stall_arvalid", if_m.arvalid, 1'b0);
        cyc(); if_s1.rready = 1'b1; #1;
        chk("t3_r1_rready", if_m.rready, 1'b1);
        chk("t3_r1_arvalid", if_m.arvalid, 1'b0);
        $display("t3 R beat to s1 data=%h", if_s1.rdata);
        cyc(); if_m.rid = 4'h1; if_m.rdata = 32'h0000_00B2; #1;
        chk("t3_r2_s0_rvalid", if_s0.rvalid, 1'b1);
        chk("t3_r2_s1_rvalid", if_s1.rvalid, 1'b0);
        chk("t3_r2_rdata", if_s0.rdata, 32'h0000_00B2);
        chk("t3_r2_rid", if_s0.rid, 3'h1);
        chk("t3_r2_arvalid", if_m.arvalid, 1'b0);
        $display("t3 R beat to s0 data=%h", if_s0.rdata);
        cyc(); if_m.rid = 4'hA; if_m.rdata = 32'h0000_00B3; #1;
        chk("t3_unblock_arvalid", if_m.arvalid, 1'b1);
        chk("t3_unblock_arid", if_m.arid, 4'hA);
        chk("t3_unblock_s1_arready", if_s1.arready, 1'b1);
        chk("t3_r3_s1_rvalid", if_s1.rvalid, 1'b1);
        chk("t3_r3_s0_rvalid", if_s0.rvalid, 1'b0);
        chk("t3_r3_rdata", if_s1.rdata, 32'h0000_00B3);
        $display("t3 R beat to s1 data=%h, third s1 AR granted", if_s1.rdata);
        cyc(); if_s1.arvalid = 1'b0; if_m.rvalid = 1'b0; if_m.rlast = 1'b0; #1;
        chk("t3_idle_arvalid", if_m.arvalid, 1'b0);
        chk("t3_idle_s1_rvalid", if_s1.rvalid, 1'b0);

        // Short s0 burst: awlen=1 but wlast on the first beat
        cyc(); if_s0.awvalid = 1'b1; if_s0.awid = 3'h3; if_s0.awaddr = 16'h0400; if_s0.awlen = 8'd1;
        cyc();
        chk("t4_awvalid", if_m.awvalid, 1'b1);
        chk("t4_awid", if_m.awid, 4'h3);
        cyc(); if_s0.awvalid = 1'b0; if_s0.wvalid = 1'b1; if_s0.wdata = 32'hC000_0000; if_s0.wlast = 1'b1; #1;
        chk("t4_s0_wready", if_s0.wready, 1'b1);
        chk("t4_wlast", if_m.wlast, 1'b1);
        cyc(); if_s0.wvalid = 1'b0; if_s0.wlast = 1'b0;
        if_m.bvalid = 1'b1; if_m.bid = 4'h3; #1;
        chk("t4_wlast_err", wlast_err, 2'b01);
        chk("t4_burst_end_wready", if_s0.wready, 1'b0);
        chk("t4_s0_bvalid", if_s0.bvalid, 1'b1);
        $display("t4 write s0 id=3 short burst, wlast_err=%b", wlast_err);
        cyc(); if_m.bvalid = 1'b0;
        if_s1.awvalid = 1'b1; if_s1.awid = 3'h4; if_s1.awaddr = 16'h0500; if_s1.awlen = 8'd1;
        cyc();
        chk("t4_s1_awvalid", if_m.awvalid, 1'b1);
        chk("t4_s1_awid", if_m.awid, 4'hC);
        chk("t4_s1_awready", if_s1.awready, 1'b1);
        chk("t4_s0_awready", if_s0.awready, 1'b0);
        for (int b = 0; b < 2; b++) begin
            cyc();
            if (b == 0) begin
                if_s1.awvalid = 1'b0;
                if_s1.wvalid  = 1'b1;
            end
            if_s1.wdata = 32'hD000_0000 + 32'(b);
            if_s1.wlast = (b == 1);
            #1;
            chk("t4_s1_wdata", if_m.wdata, 32'hD000_0000 + 32'(b));
            chk("t4_s1_wready", if_s1.wready, 1'b1);
            chk("t4_s0_wready", if_s0.wready, 1'b0);
        end
        cyc(); if_s1.wvalid = 1'b0; if_s1.wlast = 1'b0;
        if_m.bvalid = 1'b1; if_m.bid = 4'hC; if_m.bresp = 2'b10; if_s1.bready = 1'b0; #1;
        chk("t4_err_unchanged", wlast_err, 2'b01);
        chk("t4_s1_bvalid", if_s1.bvalid, 1'b1);
        chk("t4_s0_bvalid", if_s0.bvalid, 1'b0);
        chk("t4_s1_bid", if_s1.bid, 3'h4);
        chk("t4_s1_bresp", if_s1.bresp, 2'b10);
        chk("t4_bready_stall", if_m.bready, 1'b0);
        cyc(); if_s1.bready = 1'b1; #1;
        chk("t4_bready", if_m.bready, 1'b1);
        $display("t4 write s1 id=4 len=1 complete, wlast_err=%b", wlast_err);
        cyc(); if_m.bvalid = 1'b0; if_m.bresp = 2'b00;

        // Reset during beat 2 of a 4-beat s0 burst
        cyc(); if_s0.awvalid = 1'b1; if_s0.awid = 3'h6; if_s0.awaddr = 16'h0600; if_s0.awlen = 8'd3;
        cyc();
        chk("t5_awvalid", if_m.awvalid, 1'b1);
        for (int b = 0; b < 2; b++) begin
            cyc();
            if (b == 0) begin
                if_s0.awvalid = 1'b0;
                if_s0.wvalid  = 1'b1;
            end
            if_s0.wdata = 32'hE000_0000 + 32'(b);
            #1;
            chk("t5_wvalid", if_m.wvalid, 1'b1);
        end
        cyc(); if_s0.wdata = 32'hE000_0002; rst = 1'b1;
        cyc();
        chk("t5_rst_wvalid", if_m.wvalid, 1'b0);
        chk("t5_rst_s0_wready", if_s0.wready, 1'b0);
        chk("t5_rst_awvalid", if_m.awvalid, 1'b0);
        chk("t5_rst_arvalid", if_m.arvalid, 1'b0);
        chk("t5_rst_s0_awready", if_s0.awready, 1'b0);
        chk("t5_rst_wlast_err", wlast_err, 2'b00);
        $display("t5 reset during s0 burst beat 2");
        cyc(); rst = 1'b0; if_s0.wvalid = 1'b0;
        cyc(); if_s1.awvalid = 1'b1; if_s1.awid = 3'h7; if_s1.awaddr = 16'h0700; if_s1.awlen = 8'd0; #1;
        chk("t5_s1_aw_latency", if_m.awvalid, 1'b0);
        cyc();
        chk("t5_s1_awvalid", if_m.awvalid, 1'b1);
        chk("t5_s1_awid", if_m.awid, 4'hF);
        cyc(); if_s1.awvalid = 1'b0; if_s1.wvalid = 1'b1; if_s1.wdata = 32'hF000_0000; if_s1.wlast = 1'b1; #1;
        chk("t5_s1_wdata", if_m.wdata, 32'hF000_0000);
        chk("t5_s1_wready", if_s1.wready, 1'b1);
        cyc(); if_s1.wvalid = 1'b0; if_s1.wlast = 1'b0; if_m.bvalid = 1'b1; if_m.bid = 4'hF; #1;
        chk("t5_s1_wlast_err", wlast_err, 2'b00);
        chk("t5_s1_bvalid", if_s1.bvalid, 1'b1);
        $display("t5 write s1 id=7 len=0 complete after reset");
        cyc(); if_m.bvalid = 1'b0;

        // Read counters cleared by reset: s1 gets MAX_OUT grants again
        if_s1.arvalid = 1'b1; if_s1.arid = 3'h5; if_s1.araddr = 16'h0800; #1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("t6_arvalid", if_m.arvalid, 1'b1);
            chk("t6_arid", if_m.arid, 4'hD);
            $display("t6 AR grant %0d arid=%h", i, if_m.arid);
            cyc();
            chk("t6_ar_gap", if_m.arvalid, 1'b0);
        end
        cyc();
        chk("t6_full_arvalid", if_m.arvalid, 1'b0);
        if_s1.arvalid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
